// File: rtl/f_fetch_unit_pkg.sv
// Shared CPU definitions: exception codes, fixed PC addresses and instruction-memory bounds.
package cpu_defs;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam logic [31:0] PC_RESET_ADDR  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_ADDR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_ADDR   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_ADDR  = 32'h0000_6FFC;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_ERET,
    NPC_HOLD,
    NPC_BRANCH,
    NPC_SEQ
  } npc_src_t;

endpackage

// File: rtl/f_fetch_unit_npc_sel.sv
// Next-PC priority mux: exception > eret > stall > branch/jump > sequential.
module f_npc_sel
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_ADDR
) (
  input  logic [31:0] pc,
  input  logic        f_we,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  output logic [31:0] npc
);

  npc_src_t src;

  always_comb begin
    src = NPC_SEQ;
    if (exc_req)      src = NPC_EXC;
    else if (eret)    src = NPC_ERET;
    else if (!f_we)   src = NPC_HOLD;
    else if (npc_sel) src = NPC_BRANCH;
  end

  always_comb begin
    npc = pc + 32'd4;
    unique case (src)
      NPC_EXC:    npc = EXC_ENTRY;
      NPC_ERET:   npc = cp0_epc;
      NPC_HOLD:   npc = pc;
      NPC_BRANCH: npc = npc_target;
      default:    npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/f_fetch_unit.sv
// F stage of the P7 MIPS core: PC register, AdEL fetch check and F->D outputs.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module f_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_ADDR,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_ADDR,
  parameter logic [31:0] IM_BASE   = IM_BASE_ADDR,
  parameter logic [31:0] IM_LIMIT  = IM_LIMIT_ADDR
) (
  input  logic        clk,
  input  logic        res,
  input  logic        F_WE,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        D_is_jump,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_command,
  output logic [31:0] F_PC,
  output logic [31:0] F_EPC,
  output logic [4:0]  F_exc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] F_fetch_cnt,
  output logic [31:0] F_stall_cnt,
`endif
  output logic        F_BD
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic        adel;

  f_npc_sel #(
    .EXC_ENTRY(EXC_ENTRY)
  ) u_npc_sel (
    .pc        (pc),
    .f_we      (F_WE),
    .npc_sel   (npc_sel),
    .npc_target(npc_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .cp0_epc   (cp0_epc),
    .npc       (npc)
  );

  always_ff @(posedge clk) begin
    if (res) pc <= PC_RESET;
    else     pc <= npc;
  end

  // Illegal targets are accepted into the PC; the fault surfaces here on fetch.
  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
  end

  always_comb begin
    i_inst_addr = pc;
    F_PC        = pc;
    F_BD        = D_is_jump;
    F_EPC       = D_is_jump ? (pc - 32'd4) : pc;
    F_exc       = adel ? EXC_ADEL : EXC_NONE;
    F_command   = adel ? '0 : i_inst_rdata;
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_hit;

  always_comb begin
    stall_hit = !F_WE && !exc_req && !eret;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      F_fetch_cnt <= '0;
      F_stall_cnt <= '0;
    end else begin
      if (npc != pc) F_fetch_cnt <= F_fetch_cnt + 32'd1;
      if (stall_hit) F_stall_cnt <= F_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed self-checking bench for f_fetch_unit.
module tb_f_fetch_unit;

  logic        clk;
  logic        res;
  logic        F_WE;
  logic        npc_sel;
  logic [31:0] npc_target;
  logic        D_is_jump;
  logic        exc_req;
  logic        eret;
  logic [31:0] cp0_epc;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_command;
  logic [31:0] F_PC;
  logic [31:0] F_EPC;
  logic [4:0]  F_exc;
  logic        F_BD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] F_fetch_cnt;
  logic [31:0] F_stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  f_fetch_unit dut (
    .clk         (clk),
    .res         (res),
    .F_WE        (F_WE),
    .npc_sel     (npc_sel),
    .npc_target  (npc_target),
    .D_is_jump   (D_is_jump),
    .exc_req     (exc_req),
    .eret        (eret),
    .cp0_epc     (cp0_epc),
    .i_inst_addr (i_inst_addr),
    .i_inst_rdata(i_inst_rdata),
    .F_command   (F_command),
    .F_PC        (F_PC),
    .F_EPC       (F_EPC),
    .F_exc       (F_exc),
`ifdef FETCH_PERF_CNT_EN
    .F_fetch_cnt (F_fetch_cnt),
    .F_stall_cnt (F_stall_cnt),
`endif
    .F_BD        (F_BD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    res = 1'b0; F_WE = 1'b1; npc_sel = 1'b0; npc_target = '0;
    D_is_jump = 1'b0; exc_req = 1'b0; eret = 1'b0; cp0_epc = '0;
    i_inst_rdata = 32'h2401_0001;
  endtask

  // Apply the current inputs for one edge, then leave time for outputs to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle_inputs();
    npc_sel = 1'b1; npc_target = addr;
    step();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    res = 1'b1; exc_req = 1'b1; eret = 1'b1; cp0_epc = 32'h0000_3044; F_WE = 1'b0;
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (F_PC !== 32'h0000_3000) begin
      tests_failed++; $display("FAIL reset_pc got=%h exp=%h", F_PC, 32'h0000_3000);
    end
    tests_run++;
    if (F_EPC !== 32'h0000_3000 || F_exc !== 5'd0 || F_BD !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got epc=%h exc=%0d bd=%b exp epc=00003000 exc=0 bd=0", F_EPC, F_exc, F_BD);
    end
  endtask

  task automatic test_sequential();
    step();
    tests_run++;
    if (F_PC !== 32'h0000_3004) begin
      tests_failed++; $display("FAIL seq_pc1 got=%h exp=%h", F_PC, 32'h0000_3004);
    end
    step();
    tests_run++;
    if (F_PC !== 32'h0000_3008 || i_inst_addr !== 32'h0000_3008) begin
      tests_failed++; $display("FAIL seq_pc2 got=%h addr=%h exp=%h", F_PC, i_inst_addr, 32'h0000_3008);
    end
    tests_run++;
    if (F_command !== 32'h2401_0001 || F_exc !== 5'd0) begin
      tests_failed++; $display("FAIL seq_cmd got=%h exc=%0d exp=24010001 exc=0", F_command, F_exc);
    end
  endtask

  task automatic test_stall_redirect();
    jump_to(32'h0000_3010);
    F_WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (F_PC !== 32'h0000_3010) begin
        tests_failed++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, F_PC, 32'h0000_3010);
      end
    end
    F_WE = 1'b1; npc_sel = 1'b1; npc_target = 32'h0000_3100;
    step();
    tests_run++;
    if (F_PC !== 32'h0000_3100) begin
      tests_failed++; $display("FAIL redirect got=%h exp=%h", F_PC, 32'h0000_3100);
    end
  endtask

  task automatic test_exception();
    jump_to(32'h0000_3020);
    F_WE = 1'b0; exc_req = 1'b1;
    step();
    tests_run++;
    if (F_PC !== 32'h0000_4180) begin
      tests_failed++; $display("FAIL exc_in_stall got=%h exp=%h", F_PC, 32'h0000_4180);
    end
    jump_to(32'h0000_3020);
    F_WE = 1'b0; exc_req = 1'b1; eret = 1'b1; cp0_epc = 32'h0000_3044;
    npc_sel = 1'b1; npc_target = 32'h0000_3100;
    step();
    tests_run++;
    if (F_PC !== 32'h0000_4180) begin
      tests_failed++; $display("FAIL exc_over_eret got=%h exp=%h", F_PC, 32'h0000_4180);
    end
  endtask

  task automatic test_eret();
    idle_inputs();
    F_WE = 1'b0; eret = 1'b1; cp0_epc = 32'h0000_3044;
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (F_PC !== 32'h0000_3044 || F_exc !== 5'd0) begin
      tests_failed++; $display("FAIL eret got=%h exc=%0d exp=00003044 exc=0", F_PC, F_exc);
    end
  endtask

  task automatic test_adel();
    jump_to(32'h0000_3002);
    tests_run++;
    if (F_PC !== 32'h0000_3002 || i_inst_addr !== 32'h0000_3002) begin
      tests_failed++; $display("FAIL adel_misalign_pc got=%h addr=%h exp=00003002", F_PC, i_inst_addr);
    end
    tests_run++;
    if (F_exc !== 5'd4 || F_command !== 32'h0) begin
      tests_failed++; $display("FAIL adel_misalign got exc=%0d cmd=%h exp exc=4 cmd=0", F_exc, F_command);
    end
    jump_to(32'h0000_7000);
    tests_run++;
    if (F_exc !== 5'd4) begin
      tests_failed++; $display("FAIL adel_above got=%0d exp=4", F_exc);
    end
    jump_to(32'h0000_6FFC);
    tests_run++;
    if (F_exc !== 5'd0 || F_command !== 32'h2401_0001) begin
      tests_failed++; $display("FAIL limit_legal got exc=%0d cmd=%h exp exc=0 cmd=24010001", F_exc, F_command);
    end
    jump_to(32'h0000_2FFC);
    tests_run++;
    if (F_exc !== 5'd4) begin
      tests_failed++; $display("FAIL adel_below got=%0d exp=4", F_exc);
    end
    jump_to(32'h0000_3000);
    tests_run++;
    if (F_exc !== 5'd0) begin
      tests_failed++; $display("FAIL base_legal got=%0d exp=0", F_exc);
    end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    step();
    tests_run++;
    if (F_PC !== 32'h0000_0000 || F_exc !== 5'd4) begin
      tests_failed++; $display("FAIL pc_wrap got=%h exc=%0d exp=00000000 exc=4", F_PC, F_exc);
    end
  endtask

  task automatic test_delay_slot();
    jump_to(32'h0000_3008);
    D_is_jump = 1'b1;
    #1;
    tests_run++;
    if (F_BD !== 1'b1 || F_EPC !== 32'h0000_3004) begin
      tests_failed++; $display("FAIL bd_epc got bd=%b epc=%h exp bd=1 epc=00003004", F_BD, F_EPC);
    end
    D_is_jump = 1'b0;
    #1;
    tests_run++;
    if (F_BD !== 1'b0 || F_EPC !== 32'h0000_3008) begin
      tests_failed++; $display("FAIL nobd_epc got bd=%b epc=%h exp bd=0 epc=00003008", F_BD, F_EPC);
    end
  endtask

  task automatic test_reset_mid_redirect();
    jump_to(32'h0000_3400);
    F_WE = 1'b0;
    step();
    res = 1'b1; F_WE = 1'b1; npc_sel = 1'b1; npc_target = 32'h0000_3100;
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (F_PC !== 32'h0000_3000) begin
      tests_failed++; $display("FAIL reset_over_redirect got=%h exp=%h", F_PC, 32'h0000_3000);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_exception();
    test_eret();
    test_adel();
    test_wrap();
    test_delay_slot();
    test_reset_mid_redirect();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
